sketch_ingest_feeder: RTL

Upstream front end for the distribution sketch top. Buffers incoming (flow ID, latency) records in a FIFO and sequences them one at a time into the sketch's insert handshake, and serialises quantile queries into the sketch's search handshake. Queries are ordered behind every record accepted before them, so each result reflects all earlier inserts. It drives the sketch's insert/search inputs and consumes its end strobes and result.

---
 rtl/sketch_ingest_feeder.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/sketch_ingest_feeder.sv
// sketch_ingest_feeder: front end for the distribution sketch.
// Buffers (flow ID, latency) records in a FIFO and feeds them one at a time
// into the sketch insert handshake. Quantile queries are held in a single
// slot and issued to the search handshake only after every record accepted
// before the query has been inserted (or aborted).
//
// Ports:
//   clk, rst                      clock, async active-low reset
//   rec_valid_i/rec_ready_o       record write handshake, rec_id_i/rec_latency_i payload
//   cfg_freq_th_i                 frequency threshold, sampled while idle
//   qry_valid_i/qry_ready_o       query load handshake, qry_id_i/qry_quantile_i payload
//   insert_o, insert_*_o          sketch insert request and data
//   insert_end_i                  sketch insert completion
//   search_o, search_*_o          sketch search request and data
//   search_end_i/search_latency_i sketch search completion and result
//   result_valid_o/result_latency_o  one-cycle result strobe, held result value
//   err_timeout_o                 one-cycle pulse when an operation is aborted
//   stat_ins_cnt_o/stat_to_cnt_o  completed inserts / aborts
//
// Optional feature: define FEEDER_STATS_EN to build the statistics counters;
// otherwise both stat outputs are tied to zero.
module sketch_ingest_feeder #(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned WAIT_MAX = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rec_valid_i,
   output logic        rec_ready_o,
   input  logic [63:0] rec_id_i,
   input  logic [63:0] rec_latency_i,
   input  logic [63:0] cfg_freq_th_i,
   input  logic        qry_valid_i,
   output logic        qry_ready_o,
   input  logic [63:0] qry_id_i,
   input  logic [63:0] qry_quantile_i,
   output logic        insert_o,
   output logic [63:0] insert_id_o,
   output logic [63:0] insert_latency_o,
   output logic [63:0] insert_freq_th_o,
   input  logic        insert_end_i,
   output logic        search_o,
   output logic [63:0] search_id_o,
   output logic [63:0] search_quantile_o,
   input  logic        search_end_i,
   input  logic [63:0] search_latency_i,
   output logic        result_valid_o,
   output logic [63:0] result_latency_o,
   output logic        err_timeout_o,
   output logic [31:0] stat_ins_cnt_o,
   output logic [15:0] stat_to_cnt_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam int unsigned WW = $clog2(WAIT_MAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_INSERT, S_GAP, S_SEARCH} state_t;

   state_t        r_state, w_state_nxt;
   logic [63:0]   r_mem_id  [DEPTH];
   logic [63:0]   r_mem_lat [DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [CW-1:0] r_count, w_count_nxt, r_pending;
   logic          r_rec_ready, r_qry_ready;
   logic [63:0]   r_qry_id, r_qry_q;
   logic          r_insert, r_search;
   logic [63:0]   r_ins_id, r_ins_lat, r_freq_th, r_res_lat;
   logic          r_res_valid, r_err;
   logic [WW-1:0] r_wait;
   logic          w_wr, w_qry_ld, w_pop, w_ins_done, w_srch_done, w_abort, w_qry_free;
   logic          w_wait_hit;

   assign w_wr        = rec_valid_i && r_rec_ready;
   assign w_qry_ld    = qry_valid_i && r_qry_ready;
   assign w_count_nxt = r_count + CW'(w_wr) - CW'(w_pop);
   assign w_wait_hit  = (r_wait >= WW'(WAIT_MAX - 1));

   // Record storage: payload only, no reset needed
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem_id[r_wr_ptr]  <= rec_id_i;
         r_mem_lat[r_wr_ptr] <= rec_latency_i;
      end
   end

   // Next-state and handshake decode; completions only count while the strobe is up
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_ins_done  = 1'b0;
      w_srch_done = 1'b0;
      w_abort     = 1'b0;
      w_qry_free  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!r_qry_ready && (r_pending == '0)) w_state_nxt = S_SEARCH;
            else if (r_count != '0)                  w_state_nxt = S_INSERT;
         end
         S_INSERT: begin
            if (r_insert) begin
               if (insert_end_i) begin
                  w_pop       = 1'b1;
                  w_ins_done  = 1'b1;
                  w_state_nxt = S_GAP;
               end else if (w_wait_hit) begin
                  w_pop       = 1'b1;
                  w_abort     = 1'b1;
                  w_state_nxt = S_GAP;
               end
            end
         end
         S_SEARCH: begin
            if (r_search) begin
               if (search_end_i) begin
                  w_srch_done = 1'b1;
                  w_qry_free  = 1'b1;
                  w_state_nxt = S_GAP;
               end else if (w_wait_hit) begin
                  w_qry_free  = 1'b1;
                  w_abort     = 1'b1;
                  w_state_nxt = S_GAP;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, FIFO pointers, and registered strobes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_rec_ready <= 1'b1;
         r_insert    <= 1'b0;
         r_search    <= 1'b0;
         r_wait      <= '0;
         r_ins_id    <= '0;
         r_ins_lat   <= '0;
         r_freq_th   <= '0;
         r_res_valid <= 1'b0;
         r_res_lat   <= '0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_count     <= w_count_nxt;
         r_rec_ready <= (w_count_nxt != CW'(DEPTH));
         if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         // Strobes rise one cycle after the state is entered and drop on the completing edge
         r_insert    <= (r_state == S_INSERT) && (w_state_nxt == S_INSERT);
         r_search    <= (r_state == S_SEARCH) && (w_state_nxt == S_SEARCH);
         // Wait counter is held clear while idle, so every operation starts from zero
         if (r_state == S_IDLE)
            r_wait <= '0;
         else if ((r_insert || r_search) && (r_wait != WW'(WAIT_MAX)))
            r_wait <= r_wait + WW'(1);
         if ((r_state == S_IDLE) && (w_state_nxt == S_INSERT)) begin
            r_ins_id  <= r_mem_id[r_rd_ptr];
            r_ins_lat <= r_mem_lat[r_rd_ptr];
         end
         if (r_state == S_IDLE) r_freq_th <= cfg_freq_th_i;
         r_res_valid <= w_srch_done;
         if (w_srch_done) r_res_lat <= search_latency_i;
         r_err       <= w_abort;
      end
   end

   // Query slot; pending counts records ahead of the query, including one written this cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_qry_ready <= 1'b1;
         r_qry_id    <= '0;
         r_qry_q     <= '0;
         r_pending   <= '0;
      end else if (w_qry_ld) begin
         r_qry_ready <= 1'b0;
         r_qry_id    <= qry_id_i;
         r_qry_q     <= qry_quantile_i;
         r_pending   <= w_count_nxt;
      end else begin
         if (w_qry_free) r_qry_ready <= 1'b1;
         if (w_pop && (r_pending != '0)) r_pending <= r_pending - CW'(1);
      end
   end

`ifdef FEEDER_STATS_EN
   logic [31:0] r_ins_cnt;
   logic [15:0] r_to_cnt;

   // Completed inserts wrap; aborts saturate
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ins_cnt <= '0;
         r_to_cnt  <= '0;
      end else begin
         if (w_ins_done) r_ins_cnt <= r_ins_cnt + 32'd1;
         if (w_abort && (r_to_cnt != 16'hFFFF)) r_to_cnt <= r_to_cnt + 16'd1;
      end
   end

   assign stat_ins_cnt_o = r_ins_cnt;
   assign stat_to_cnt_o  = r_to_cnt;
`else
   assign stat_ins_cnt_o = '0;
   assign stat_to_cnt_o  = '0;
`endif

   assign rec_ready_o       = r_rec_ready;
   assign qry_ready_o       = r_qry_ready;
   assign insert_o          = r_insert;
   assign insert_id_o       = r_ins_id;
   assign insert_latency_o  = r_ins_lat;
   assign insert_freq_th_o  = r_freq_th;
   assign search_o          = r_search;
   assign search_id_o       = r_qry_id;
   assign search_quantile_o = r_qry_q;
   assign result_valid_o    = r_res_valid;
   assign result_latency_o  = r_res_lat;
   assign err_timeout_o     = r_err;

endmodule
